// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code bus receiver.
// gray2bin works on a zero-extended word, so any width up to GRAY_MAX_W can use it.
package gray_pkg;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int GRAY_MAX_W          = 64;

  typedef enum logic {RX_IDLE, RX_TRACK} rx_state_t;

  // Leading zeros decode to zeros, so callers zero-extend and truncate the result.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync_pipe.sv
// SYNC_STAGES-deep register chain carrying {bus_en, bus_data} side by side.
// Data is forced to zero when the enable is low, so a floating bus never propagates.
module gray_sync_pipe import gray_pkg::*; #(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] bus_data,
  input  logic             bus_en,
  output logic [WIDTH-1:0] sync_data,
  output logic             sync_en
);

  logic [WIDTH-1:0]       data_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] en_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_q[i] <= '0;
      end
      en_q <= '0;
    end else begin
      data_q[0] <= bus_en ? bus_data : '0;
      en_q[0]   <= bus_en;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_q[i] <= data_q[i-1];
        en_q[i]   <= en_q[i-1];
      end
    end
  end

  assign sync_data = data_q[SYNC_STAGES-1];
  assign sync_en   = en_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_bus_receiver.sv
// Gray-code bus receiver: sync, decode, lock onto the count and flag sequence breaks.
// Status outputs (locked, seq_error, counters) follow the sample on bin_data by one cycle.
module gray_bus_receiver import gray_pkg::*; #(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int ERR_W       = 8,
  parameter int LOSS_LIMIT  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] bus_data,
  input  logic             bus_en,
  input  logic             clear_errors,
  output logic [WIDTH-1:0] bin_data,
  output logic             data_valid,
  output logic             locked,
  output logic             seq_error,
  output logic             sticky_error,
  output logic [ERR_W-1:0] err_count
);

  localparam int MISS_W = (LOSS_LIMIT < 2) ? 1 : $clog2(LOSS_LIMIT + 1);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  logic [WIDTH-1:0]  sync_data;
  logic              sync_en;
  logic [WIDTH-1:0]  gray_p0;
  logic              vld_p0;
  rx_state_t         state_q, state_d;
  logic [WIDTH-1:0]  expected_q, expected_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              mismatch;

  gray_sync_pipe #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .bus_data  (bus_data),
    .bus_en    (bus_en),
    .sync_data (sync_data),
    .sync_en   (sync_en)
  );

  // p0: capture the synchronised Gray word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gray_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      gray_p0 <= sync_data;
      vld_p0  <= sync_en;
    end
  end

  // p1: registered binary decode; holds the last value while invalid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_data   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= vld_p0;
      if (vld_p0) begin
        bin_data <= WIDTH'(gray2bin(GRAY_MAX_W'(gray_p0)));
      end
    end
  end

  // p2: lock FSM and error bookkeeping on the p1 sample
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    miss_d     = miss_q;
    mismatch   = 1'b0;
    if (!data_valid) begin
      state_d = RX_IDLE;
      miss_d  = '0;
    end else begin
      expected_d = bin_data + WIDTH'(1);
      case (state_q)
        RX_IDLE: begin
          state_d = RX_TRACK;
          miss_d  = '0;
        end
        RX_TRACK: begin
          if (bin_data == expected_q) begin
            miss_d = '0;
          end else begin
            mismatch = 1'b1;
            if (miss_q == MISS_W'(LOSS_LIMIT - 1)) begin
              state_d = RX_IDLE;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RX_IDLE;
      expected_q   <= '0;
      miss_q       <= '0;
      seq_error    <= 1'b0;
      sticky_error <= 1'b0;
      err_count    <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      miss_q     <= miss_d;
      seq_error  <= mismatch;
      // Clear takes priority over a coincident mismatch; the pulse itself still fires.
      if (clear_errors) begin
        sticky_error <= 1'b0;
        err_count    <= '0;
      end else if (mismatch) begin
        sticky_error <= 1'b1;
        err_count    <= sat_inc(err_count);
      end
    end
  end

  assign locked = (state_q == RX_TRACK);

endmodule

// File: tb/tb_gray_bus_receiver.sv
// Directed bench for gray_bus_receiver: vector table for streaming behaviour,
// hand-written sequences for reset, saturation and clear timing.
module tb_gray_bus_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus_data;
  logic       bus_en;
  logic       clear_errors;
  logic [7:0] bin_data;
  logic       data_valid;
  logic       locked;
  logic       seq_error;
  logic       sticky_error;
  logic [7:0] err_count;

  int total_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    logic       en;
    logic [7:0] val;
    logic [7:0] exp_bin;
    logic       exp_lock;
    logic       exp_seq;
    logic       exp_sticky;
    logic [7:0] exp_err;
  } vec_t;

  vec_t vecs[$];

  gray_bus_receiver #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .ERR_W       (8),
    .LOSS_LIMIT  (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus_data     (bus_data),
    .bus_en       (bus_en),
    .clear_errors (clear_errors),
    .bin_data     (bin_data),
    .data_valid   (data_valid),
    .locked       (locked),
    .seq_error    (seq_error),
    .sticky_error (sticky_error),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_gray(input logic [7:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic void add(input logic en, input logic [7:0] val, input logic [7:0] eb,
                              input logic el, input logic es, input logic est,
                              input logic [7:0] ee);
    vec_t v;
    v.en = en; v.val = val; v.exp_bin = eb; v.exp_lock = el;
    v.exp_seq = es; v.exp_sticky = est; v.exp_err = ee;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic drive(input logic en, input logic [7:0] v);
    bus_en   = en;
    bus_data = en ? to_gray(v) : 8'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a noisy bus
    reset = 1'b1; clear_errors = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_en = 1'($urandom); bus_data = 8'($urandom);
      tick();
    end
    drive(1'b0, 8'd0);
    reset = 1'b0;
    tick();
    check("rst_bin", 32'(bin_data), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_seq", 32'(seq_error), 0);
    check("rst_sticky", 32'(sticky_error), 0);
    check("rst_err", 32'(err_count), 0);

    // Clean stream 0..20
    for (int v = 0; v <= 20; v++) add(1'b1, 8'(v), 8'(v), 1'b1, 1'b0, 1'b0, 8'd0);
    // Gap, then wrap 253..1
    add(1'b0, 8'd0, 8'd20, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b1, 8'd253, 8'd253, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 8'd254, 8'd254, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 8'd255, 8'd255, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 8'd0,   8'd0,   1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 8'd1,   8'd1,   1'b1, 1'b0, 1'b0, 8'd0);
    // Gap, then single glitch 10,11,12,40,41,42
    add(1'b0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b1, 8'd10, 8'd10, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 8'd11, 8'd11, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 8'd12, 8'd12, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b1, 8'd40, 8'd40, 1'b1, 1'b1, 1'b1, 8'd1);
    add(1'b1, 8'd41, 8'd41, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b1, 8'd42, 8'd42, 1'b1, 1'b0, 1'b1, 8'd1);
    // Gap, lock on 3,4, then 5,9,2,7 loses lock; 8 relocks
    add(1'b0, 8'd0, 8'd42, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b1, 8'd3, 8'd3, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b1, 8'd4, 8'd4, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b1, 8'd5, 8'd5, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b1, 8'd9, 8'd9, 1'b1, 1'b1, 1'b1, 8'd2);
    add(1'b1, 8'd2, 8'd2, 1'b1, 1'b1, 1'b1, 8'd3);
    add(1'b1, 8'd7, 8'd7, 1'b0, 1'b1, 1'b1, 8'd4);
    add(1'b1, 8'd8, 8'd8, 1'b1, 1'b0, 1'b1, 8'd4);
    add(1'b1, 8'd9, 8'd9, 1'b1, 1'b0, 1'b1, 8'd4);
    // Four-cycle enable gap, resume at 100
    for (int i = 0; i < 4; i++) add(1'b0, 8'd0, 8'd9, 1'b0, 1'b0, 1'b1, 8'd4);
    add(1'b1, 8'd100, 8'd100, 1'b1, 1'b0, 1'b1, 8'd4);
    add(1'b1, 8'd101, 8'd101, 1'b1, 1'b0, 1'b1, 8'd4);
    add(1'b1, 8'd102, 8'd102, 1'b1, 1'b0, 1'b1, 8'd4);

    // Vector k: bin_data after 4 edges, status after 5 edges
    for (int t = 0; t < vecs.size() + 4; t++) begin
      int j, k;
      if (t < vecs.size()) drive(vecs[t].en, vecs[t].val);
      else drive(1'b0, 8'd0);
      tick();
      j = t - 3;
      k = t - 4;
      if (j >= 0 && j < vecs.size()) begin
        check($sformatf("valid[%0d]", j), 32'(data_valid), 32'(vecs[j].en));
        check($sformatf("bin[%0d]", j), 32'(bin_data), 32'(vecs[j].exp_bin));
      end
      if (k >= 0 && k < vecs.size()) begin
        check($sformatf("locked[%0d]", k), 32'(locked), 32'(vecs[k].exp_lock));
        check($sformatf("seq[%0d]", k), 32'(seq_error), 32'(vecs[k].exp_seq));
        check($sformatf("sticky[%0d]", k), 32'(sticky_error), 32'(vecs[k].exp_sticky));
        check($sformatf("err[%0d]", k), 32'(err_count), 32'(vecs[k].exp_err));
      end
    end

    // Saturation: a frozen count yields 3 errors per 4 samples
    for (int i = 0; i < 420; i++) begin
      drive(1'b1, 8'd0);
      tick();
    end
    drive(1'b0, 8'd0);
    for (int i = 0; i < 6; i++) tick();
    check("sat_err", 32'(err_count), 255);
    check("sat_sticky", 32'(sticky_error), 1);
    check("sat_locked", 32'(locked), 0);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    check("clr_err", 32'(err_count), 0);
    check("clr_sticky", 32'(sticky_error), 0);

    // Clear coincident with a mismatch: clear wins, pulse still fires
    drive(1'b1, 8'd0);  tick();
    drive(1'b1, 8'd1);  tick();
    drive(1'b1, 8'd50); tick();
    drive(1'b0, 8'd0);  tick();
    tick();
    tick();
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    check("cw_seq", 32'(seq_error), 1);
    check("cw_err", 32'(err_count), 0);
    check("cw_sticky", 32'(sticky_error), 0);
    check("cw_locked", 32'(locked), 1);
    tick();
    check("cw_seq_after", 32'(seq_error), 0);
    check("cw_err_after", 32'(err_count), 0);
    check("cw_locked_after", 32'(locked), 0);

    // Asynchronous reset mid-stream discards in-flight samples
    for (int v = 0; v < 6; v++) begin
      drive(1'b1, 8'(v));
      tick();
    end
    check("pre_rst_locked", 32'(locked), 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_bin", 32'(bin_data), 0);
    check("arst_valid", 32'(data_valid), 0);
    check("arst_locked", 32'(locked), 0);
    drive(1'b0, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("flush_valid[%0d]", i), 32'(data_valid), 0);
      check($sformatf("flush_locked[%0d]", i), 32'(locked), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
